// File: rtl/bpred_btb.sv
`default_nettype none
// ============================================================================
//  Module   : bpred_btb
//  Purpose  : Direct-mapped tagged branch target buffer with saturating
//             direction counters and an invalidate-all sweep.
//  Revision : 1.0  initial release
// ============================================================================
module bpred_btb #(
    parameter int IDX_W = 10,
    parameter int TAG_W = 8,
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lk_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        up_en,
    input  logic [31:0] up_pc,
    input  logic        up_taken,
    input  logic [31:0] up_target,
    input  logic        flush,
    output logic        busy
);

    localparam int               c_ENTRIES  = 1 << IDX_W;
    localparam logic [IDX_W-1:0] c_PTR_LAST = '1;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] c_CNT_MIN  = '0;
    localparam logic [CNT_W-1:0] c_CNT_WEAK = CNT_W'(1 << (CNT_W - 1));

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_IDLE  = 1'b1;

    logic             r_valid  [c_ENTRIES];
    logic [TAG_W-1:0] r_tag    [c_ENTRIES];
    logic [31:0]      r_target [c_ENTRIES];
    logic [CNT_W-1:0] r_cnt    [c_ENTRIES];

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_next;

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic             w_lk_taken;

    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_up_we;
    logic [CNT_W-1:0] w_up_cnt_next;

    // Bits outside the index/tag fields do not participate in the update path.
    logic [31:0]      w_unused_up_pc;
    assign w_unused_up_pc = up_pc;

    assign busy = (r_state == c_ST_CLEAR);

    assign w_lk_idx   = lk_pc[2 +: IDX_W];
    assign w_lk_tag   = lk_pc[2 + IDX_W +: TAG_W];
    assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_taken = w_lk_hit && r_cnt[w_lk_idx][CNT_W-1];

    assign w_up_idx = up_pc[2 +: IDX_W];
    assign w_up_tag = up_pc[2 + IDX_W +: TAG_W];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    // flush in IDLE takes priority, so a concurrent update is dropped
    assign w_up_we  = up_en && (r_state == c_ST_IDLE) && !flush && (w_up_hit || up_taken);

    always_comb begin
        w_up_cnt_next = r_cnt[w_up_idx];
        if (!w_up_hit) begin
            w_up_cnt_next = c_CNT_WEAK;
        end else if (up_taken) begin
            if (r_cnt[w_up_idx] != c_CNT_MAX) w_up_cnt_next = r_cnt[w_up_idx] + CNT_W'(1);
        end else begin
            if (r_cnt[w_up_idx] != c_CNT_MIN) w_up_cnt_next = r_cnt[w_up_idx] - CNT_W'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        case (r_state)
            c_ST_CLEAR: begin
                if (flush) begin
                    w_ptr_next = '0;
                end else begin
                    w_ptr_next = r_ptr + IDX_W'(1);
                    if (r_ptr == c_PTR_LAST) w_state_next = c_ST_IDLE;
                end
            end
            c_ST_IDLE: begin
                if (flush) begin
                    w_state_next = c_ST_CLEAR;
                    w_ptr_next   = '0;
                end
            end
            default: begin
                w_state_next = c_ST_CLEAR;
                w_ptr_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // Single write port: the sweep owns it while clearing, updates otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == c_ST_CLEAR) begin
                r_valid[r_ptr] <= 1'b0;
            end else if (w_up_we) begin
                r_valid[w_up_idx] <= 1'b1;
                r_tag[w_up_idx]   <= w_up_tag;
                r_cnt[w_up_idx]   <= w_up_cnt_next;
                if (up_taken) r_target[w_up_idx] <= up_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= 32'd0;
        end else if (r_state == c_ST_CLEAR) begin
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= lk_pc + 32'd4;
        end else begin
            pred_hit    <= w_lk_hit;
            pred_taken  <= w_lk_taken;
            pred_target <= w_lk_taken ? r_target[w_lk_idx] : lk_pc + 32'd4;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bpred_btb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bpred_btb
//  Purpose  : Directed self-checking bench for bpred_btb (IDX_W=4, CNT_W=2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bpred_btb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lk_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        up_en;
    logic [31:0] up_pc;
    logic        up_taken;
    logic [31:0] up_target;
    logic        flush;
    logic        busy;

    int total = 0;
    int bad   = 0;

    bpred_btb #(.IDX_W(4), .TAG_W(8), .CNT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .lk_pc       (lk_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .up_en       (up_en),
        .up_pc       (up_pc),
        .up_taken    (up_taken),
        .up_target   (up_target),
        .flush       (flush),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        up_en = 1'b1; up_pc = pc; up_taken = tk; up_target = tgt;
        tick();
        up_en = 1'b0;
    endtask

    task automatic do_lookup(input logic [31:0] pc);
        lk_pc = pc;
        tick();
    endtask

    task automatic test_reset();
        int n;
        logic [31:0] exp_t;
        rst = 1'b1; flush = 1'b0; up_en = 1'b0; up_pc = 0; up_taken = 0; up_target = 0;
        lk_pc = 32'h0000_0ab0;
        tick(); tick();
        total++; if (pred_hit !== 1'b0)     begin bad++; $display("FAIL reset_hit got=%b exp=0", pred_hit); end
        total++; if (pred_taken !== 1'b0)   begin bad++; $display("FAIL reset_taken got=%b exp=0", pred_taken); end
        total++; if (pred_target !== 32'd0) begin bad++; $display("FAIL reset_target got=%h exp=0", pred_target); end
        total++; if (busy !== 1'b1)         begin bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            lk_pc = 32'h0000_1000 + 32'(n * 4);
            exp_t = lk_pc + 32'd4;
            up_en = 1'b1; up_pc = 32'h100; up_taken = 1'b1; up_target = 32'h900;
            tick();
            n++;
            total++;
            if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== exp_t) begin
                bad++;
                $display("FAIL sweep_out cyc=%0d got hit=%b tk=%b tgt=%h exp hit=0 tk=0 tgt=%h",
                         n, pred_hit, pred_taken, pred_target, exp_t);
            end
        end
        up_en = 1'b0;
        total++; if (n != 16) begin bad++; $display("FAIL sweep_len got=%0d exp=16", n); end
        do_lookup(32'h100);
        total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL dropped_update got hit=%b exp=0", pred_hit); end
    endtask

    task automatic test_alloc();
        lk_pc = 32'h0;
        do_update(32'h100, 1'b1, 32'h200);
        do_lookup(32'h100);
        total++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h200) begin
            bad++; $display("FAIL alloc got hit=%b tk=%b tgt=%h exp 1 1 00000200", pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_hysteresis();
        do_update(32'h100, 1'b0, 32'h0);
        do_lookup(32'h100);
        total++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            bad++; $display("FAIL hyst_nt1 got hit=%b tk=%b tgt=%h exp 1 0 00000104", pred_hit, pred_taken, pred_target);
        end
        for (int i = 0; i < 3; i++) do_update(32'h100, 1'b1, 32'h200);
        do_lookup(32'h100);
        total++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
            bad++; $display("FAIL hyst_sat got tk=%b tgt=%h exp 1 00000200", pred_taken, pred_target);
        end
        do_update(32'h100, 1'b0, 32'h0);
        do_lookup(32'h100);
        total++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
            bad++; $display("FAIL hyst_one_nt got tk=%b tgt=%h exp 1 00000200", pred_taken, pred_target);
        end
        do_update(32'h100, 1'b0, 32'h0);
        do_lookup(32'h100);
        total++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            bad++; $display("FAIL hyst_two_nt got hit=%b tk=%b tgt=%h exp 1 0 00000104", pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_alias();
        do_lookup(32'h140);
        total++;
        if (pred_hit !== 1'b0 || pred_target !== 32'h144) begin
            bad++; $display("FAIL alias_look got hit=%b tgt=%h exp 0 00000144", pred_hit, pred_target);
        end
        do_update(32'h140, 1'b1, 32'h500);
        do_lookup(32'h100);
        total++;
        if (pred_hit !== 1'b0 || pred_target !== 32'h104) begin
            bad++; $display("FAIL alias_evict got hit=%b tgt=%h exp 0 00000104", pred_hit, pred_target);
        end
        do_lookup(32'h140);
        total++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h500) begin
            bad++; $display("FAIL alias_new got hit=%b tk=%b tgt=%h exp 1 1 00000500", pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_back_to_back();
        lk_pc = 32'h300;
        do_update(32'h300, 1'b1, 32'h400);
        total++;
        if (pred_hit !== 1'b0 || pred_target !== 32'h304) begin
            bad++; $display("FAIL rbw_same got hit=%b tgt=%h exp 0 00000304", pred_hit, pred_target);
        end
        tick();
        total++;
        if (pred_hit !== 1'b1 || pred_target !== 32'h400) begin
            bad++; $display("FAIL rbw_next got hit=%b tgt=%h exp 1 00000400", pred_hit, pred_target);
        end
    endtask

    // Runs a sweep started by flush; restart_at>0 injects flush (or rst) in that busy cycle.
    task automatic run_sweep(input int restart_at, input logic use_rst, output int n);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (n + 1 == restart_at) begin
                if (use_rst) rst = 1'b1; else flush = 1'b1;
            end
            tick();
            rst = 1'b0; flush = 1'b0;
            n++;
        end
    endtask

    task automatic test_flush();
        int n;
        run_sweep(0, 1'b0, n);
        total++; if (n != 16) begin bad++; $display("FAIL flush_len got=%0d exp=16", n); end
        do_lookup(32'h300);
        total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL flush_clear got hit=%b exp=0", pred_hit); end
    endtask

    task automatic test_flush_restart();
        int n;
        do_update(32'h100, 1'b1, 32'h200);
        run_sweep(5, 1'b0, n);
        total++; if (n != 21) begin bad++; $display("FAIL flush_restart_len got=%0d exp=21", n); end
        do_update(32'h180, 1'b1, 32'h280);
        run_sweep(3, 1'b1, n);
        total++; if (n != 19) begin bad++; $display("FAIL rst_restart_len got=%0d exp=19", n); end
        do_lookup(32'h180);
        total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL rst_restart_clear got hit=%b exp=0", pred_hit); end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_hysteresis();
        test_alias();
        test_back_to_back();
        test_flush();
        test_flush_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
